// File: rtl/issue_hazard_ctrl.sv
// Issue/hazard sequencer between decode and execute.
// Keeps a per-register pending-write scoreboard, holds decode on RAW/WAW
// hazards, serialises jumps/branches until execute resolves them, and
// flushes fetch/decode for a fixed number of cycles after a taken redirect.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_RUN   | normal issue, subject to scoreboard hazards
//   ST_BR_WT | jump/branch issued, waiting for execute to resolve it
//   ST_FLUSH | taken redirect, fetch/decode killed while timer runs down
module issue_hazard_ctrl #(
  parameter  int n_regs_p       = 32,
  parameter  int flush_cycles_p = 2,
  parameter  int wd_cnt_p       = 16,
  localparam int wd_addr_p      = $clog2(n_regs_p)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_dec_valid,
  input  logic [wd_addr_p-1:0] i_dec_rs1,
  input  logic [wd_addr_p-1:0] i_dec_rs2,
  input  logic                 i_dec_uses_rs1,
  input  logic                 i_dec_uses_rs2,
  input  logic [wd_addr_p-1:0] i_dec_rd,
  input  logic                 i_dec_writes_rd,
  input  logic                 i_dec_jump,
  input  logic                 i_wb_valid,
  input  logic [wd_addr_p-1:0] i_wb_rd,
  input  logic                 i_br_resolve,
  input  logic                 i_br_taken,
  output logic                 o_issue,
  output logic                 o_stall,
  output logic                 o_flush,
  output logic [n_regs_p-1:0]  o_busy,
  output logic [wd_cnt_p-1:0]  o_stall_cnt
);

  // Flush timer is a down-counter; at least one bit even for a 1-cycle flush.
  localparam int wd_fl_c = (flush_cycles_p > 1) ? $clog2(flush_cycles_p) : 1;
  localparam logic [wd_fl_c-1:0]  fl_load_c  = wd_fl_c'(flush_cycles_p - 1);
  localparam logic [wd_fl_c-1:0]  fl_one_c   = wd_fl_c'(1);
  localparam logic [wd_cnt_p-1:0] cnt_one_c  = wd_cnt_p'(1);
  localparam logic [wd_cnt_p-1:0] cnt_max_c  = '1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_BR_WT = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [wd_fl_c-1:0]    fl_cnt_q, fl_cnt_d;
  logic [n_regs_p-1:0]   busy_q, busy_d;
  logic [wd_cnt_p-1:0]   stall_cnt_q, stall_cnt_d;

  logic                  rs1_hit;
  logic                  rs2_hit;
  logic                  rd_hit;
  logic                  hazard;
  logic                  issue;
  logic                  stall;
  logic                  fl_done;

  // Hazard detect against the registered scoreboard only; a same-cycle
  // writeback is deliberately not bypassed.
  always_comb begin
    rs1_hit = i_dec_uses_rs1  & busy_q[i_dec_rs1];
    rs2_hit = i_dec_uses_rs2  & busy_q[i_dec_rs2];
    rd_hit  = i_dec_writes_rd & busy_q[i_dec_rd];
    hazard  = i_dec_valid & (rs1_hit | rs2_hit | rd_hit);
  end

  // Issue/stall handshake towards decode and execute.
  always_comb begin
    issue   = i_dec_valid & (state_q == ST_RUN) & ~hazard;
    stall   = (i_dec_valid & ~issue) | (state_q == ST_FLUSH);
    fl_done = (fl_cnt_q == '0);
  end

  // Control-flow sequencing: one outstanding jump/branch, then optional flush.
  always_comb begin
    state_d  = state_q;
    fl_cnt_d = fl_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (issue && i_dec_jump) begin
          state_d = ST_BR_WT;
        end
      end
      ST_BR_WT: begin
        if (i_br_resolve) begin
          if (i_br_taken) begin
            state_d  = ST_FLUSH;
            fl_cnt_d = fl_load_c;
          end else begin
            state_d  = ST_RUN;
          end
        end
      end
      ST_FLUSH: begin
        if (fl_done) begin
          state_d = ST_RUN;
        end else begin
          fl_cnt_d = fl_cnt_q - fl_one_c;
        end
      end
      default: begin
        state_d  = ST_RUN;
        fl_cnt_d = '0;
      end
    endcase
  end

  // Scoreboard update: clear on writeback, then set on issue so set wins.
  always_comb begin
    busy_d = busy_q;
    if (i_wb_valid && (i_wb_rd != '0)) begin
      busy_d[i_wb_rd] = 1'b0;
    end
    if (issue && i_dec_writes_rd && (i_dec_rd != '0)) begin
      busy_d[i_dec_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != cnt_max_c)) begin
      stall_cnt_d = stall_cnt_q + cnt_one_c;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      fl_cnt_q    <= '0;
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fl_cnt_q    <= fl_cnt_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_issue     = issue;
  assign o_stall     = stall;
  assign o_flush     = (state_q == ST_FLUSH);
  assign o_busy      = busy_q;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Bench for issue_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_issue_hazard_ctrl;

  localparam int NR = 32;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_dec_valid, i_dec_uses_rs1, i_dec_uses_rs2, i_dec_writes_rd, i_dec_jump;
  logic [4:0]  i_dec_rs1, i_dec_rs2, i_dec_rd, i_wb_rd;
  logic        i_wb_valid, i_br_resolve, i_br_taken;

  logic        o_issue, o_stall, o_flush;
  logic [31:0] o_busy;
  logic [15:0] o_stall_cnt;
  logic        b_issue, b_stall, b_flush;
  logic [31:0] b_busy;
  logic [3:0]  b_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  issue_hazard_ctrl #(.n_regs_p(NR), .flush_cycles_p(FC), .wd_cnt_p(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_dec_valid(i_dec_valid), .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2),
    .i_dec_uses_rs1(i_dec_uses_rs1), .i_dec_uses_rs2(i_dec_uses_rs2),
    .i_dec_rd(i_dec_rd), .i_dec_writes_rd(i_dec_writes_rd), .i_dec_jump(i_dec_jump),
    .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd),
    .i_br_resolve(i_br_resolve), .i_br_taken(i_br_taken),
    .o_issue(o_issue), .o_stall(o_stall), .o_flush(o_flush),
    .o_busy(o_busy), .o_stall_cnt(o_stall_cnt)
  );

  issue_hazard_ctrl #(.n_regs_p(NR), .flush_cycles_p(FC), .wd_cnt_p(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .i_dec_valid(i_dec_valid), .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2),
    .i_dec_uses_rs1(i_dec_uses_rs1), .i_dec_uses_rs2(i_dec_uses_rs2),
    .i_dec_rd(i_dec_rd), .i_dec_writes_rd(i_dec_writes_rd), .i_dec_jump(i_dec_jump),
    .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd),
    .i_br_resolve(i_br_resolve), .i_br_taken(i_br_taken),
    .o_issue(b_issue), .o_stall(b_stall), .o_flush(b_flush),
    .o_busy(b_busy), .o_stall_cnt(b_stall_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_busy;
  bit          m_wait;
  int          m_flush_left;
  int          m_cnt, m_cnt4;
  bit          m_init = 1'b0;

  function automatic bit m_hazard();
    return i_dec_valid && ((i_dec_uses_rs1 && m_busy[i_dec_rs1]) ||
                           (i_dec_uses_rs2 && m_busy[i_dec_rs2]) ||
                           (i_dec_writes_rd && m_busy[i_dec_rd]));
  endfunction

  function automatic bit m_issue();
    return i_dec_valid && !m_wait && (m_flush_left == 0) && !m_hazard();
  endfunction

  function automatic bit m_stall();
    return (i_dec_valid && !m_issue()) || (m_flush_left > 0);
  endfunction

  always @(posedge clk) begin
    bit iss;
    bit stl;
    if (!rst_n) begin
      m_busy = '0; m_wait = 0; m_flush_left = 0; m_cnt = 0; m_cnt4 = 0;
      m_init = 1'b1;
    end else if (m_init) begin
      iss = m_issue();
      stl = m_stall();
      if (stl) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15)   m_cnt4++;
      end
      if (i_wb_valid) m_busy[i_wb_rd] = 1'b0;
      if (iss && i_dec_writes_rd && i_dec_rd != 0) m_busy[i_dec_rd] = 1'b1;
      if (m_flush_left > 0) m_flush_left--;
      else if (m_wait) begin
        if (i_br_resolve) begin
          m_wait = 0;
          if (i_br_taken) m_flush_left = FC;
        end
      end else if (iss && i_dec_jump) m_wait = 1;
    end
  end

  // Compare both DUTs against the model on every falling edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("issue",      o_issue,     m_issue());
      chk("stall",      o_stall,     m_stall());
      chk("flush",      o_flush,     m_flush_left > 0);
      chk("busy",       o_busy,      m_busy);
      chk("stall_cnt",  o_stall_cnt, m_cnt);
      chk("issue4",     b_issue,     m_issue());
      chk("busy4",      b_busy,      m_busy);
      chk("stall_cnt4", b_stall_cnt, m_cnt4);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    i_dec_valid = 0; i_dec_uses_rs1 = 0; i_dec_uses_rs2 = 0; i_dec_writes_rd = 0;
    i_dec_jump = 0; i_dec_rs1 = 0; i_dec_rs2 = 0; i_dec_rd = 0;
    i_wb_valid = 0; i_wb_rd = 0; i_br_resolve = 0; i_br_taken = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    idle();
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_flush", o_flush, 0);
    chk("rst_cnt", o_stall_cnt, 0);
    chk("rst_issue", o_issue, 0);

    // RAW on x5
    i_dec_valid = 1; i_dec_writes_rd = 1; i_dec_rd = 5;
    #1 chk("raw_issue_add", o_issue, 1);
    cyc(); idle();
    i_dec_valid = 1; i_dec_uses_rs1 = 1; i_dec_rs1 = 5;
    #1 chk("raw_busy5", o_busy, 32'h20);
    chk("raw_stall", o_stall, 1);
    chk("raw_noissue", o_issue, 0);
    cyc();
    i_wb_valid = 1; i_wb_rd = 5;
    #1 chk("raw_wb_no_bypass", o_stall, 1);
    cyc();
    i_wb_valid = 0;
    #1 chk("raw_issue_after_wb", o_issue, 1);
    chk("raw_busy_clear", o_busy, 0);
    cyc(); idle();

    // x0 never becomes busy
    i_dec_valid = 1; i_dec_writes_rd = 1; i_dec_rd = 0;
    #1 chk("x0_issue", o_issue, 1);
    cyc();
    i_dec_writes_rd = 0; i_dec_uses_rs1 = 1; i_dec_rs1 = 0;
    i_wb_valid = 1; i_wb_rd = 0;
    #1 chk("x0_busy", o_busy, 0);
    chk("x0_read_issue", o_issue, 1);
    cyc(); idle();

    // same-cycle set and clear on x7: set wins
    i_dec_valid = 1; i_dec_writes_rd = 1; i_dec_rd = 7;
    i_wb_valid = 1; i_wb_rd = 7;
    #1 chk("sc_issue", o_issue, 1);
    cyc(); idle();
    #1 chk("sc_busy7", o_busy, 32'h80);
    i_wb_valid = 1; i_wb_rd = 7;
    cyc(); idle();
    #1 chk("sc_busy_clear", o_busy, 0);

    // taken branch
    i_dec_valid = 1; i_dec_jump = 1;
    #1 chk("tk_issue_beq", o_issue, 1);
    cyc(); idle();
    i_dec_valid = 1;
    #1 chk("tk_wait_stall", o_stall, 1);
    chk("tk_wait_noissue", o_issue, 0);
    i_br_resolve = 1; i_br_taken = 1;
    cyc();
    i_br_resolve = 0; i_br_taken = 0;
    #1 chk("tk_flush1", o_flush, 1);
    chk("tk_flush1_stall", o_stall, 1);
    cyc();
    i_dec_valid = 0;
    #1 chk("tk_flush2", o_flush, 1);
    chk("tk_flush2_stall", o_stall, 1);
    cyc();
    i_dec_valid = 1;
    #1 chk("tk_resume_flush", o_flush, 0);
    chk("tk_resume_issue", o_issue, 1);
    cyc(); idle();

    // not taken, then a spurious resolve in RUN
    i_dec_valid = 1; i_dec_jump = 1;
    cyc(); idle();
    i_br_resolve = 1; i_br_taken = 0;
    #1 chk("nt_flush", o_flush, 0);
    cyc(); idle();
    i_dec_valid = 1; i_br_resolve = 1; i_br_taken = 1;
    #1 chk("nt_run_issue", o_issue, 1);
    cyc(); idle();
    i_dec_valid = 1;
    #1 chk("spur_flush", o_flush, 0);
    chk("spur_issue", o_issue, 1);
    cyc(); idle();

    // reset during FLUSH with x5, x7 pending
    i_dec_valid = 1; i_dec_writes_rd = 1; i_dec_rd = 5;
    cyc();
    i_dec_rd = 7;
    cyc(); idle();
    i_dec_valid = 1; i_dec_jump = 1;
    cyc(); idle();
    i_br_resolve = 1; i_br_taken = 1;
    cyc(); idle();
    #1 chk("rf_in_flush", o_flush, 1);
    chk("rf_busy_a0", o_busy, 32'hA0);
    rst_n = 0;
    cyc();
    rst_n = 1;
    #1 chk("rf_busy", o_busy, 0);
    chk("rf_flush", o_flush, 0);
    chk("rf_cnt", o_stall_cnt, 0);
    chk("rf_cnt4", b_stall_cnt, 0);

    // stall counter saturation: 20 stalled cycles
    i_dec_valid = 1; i_dec_writes_rd = 1; i_dec_rd = 3;
    cyc(); idle();
    i_dec_valid = 1; i_dec_uses_rs1 = 1; i_dec_rs1 = 3;
    repeat (20) cyc();
    #1 chk("sat_cnt4", b_stall_cnt, 15);
    chk("sat_cnt16", o_stall_cnt, 20);
    idle();
    i_wb_valid = 1; i_wb_rd = 3;
    cyc(); idle();

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst_n           = ($urandom_range(0, 299) != 0);
      i_dec_valid     = ($urandom_range(0, 3) != 0);
      i_dec_rs1       = 5'($urandom_range(0, 7));
      i_dec_rs2       = 5'($urandom_range(0, 7));
      i_dec_rd        = 5'($urandom_range(0, 7));
      i_dec_uses_rs1  = 1'($urandom);
      i_dec_uses_rs2  = 1'($urandom);
      i_dec_writes_rd = 1'($urandom);
      i_dec_jump      = ($urandom_range(0, 7) == 0);
      i_wb_valid      = 1'($urandom);
      i_wb_rd         = 5'($urandom_range(0, 7));
      i_br_resolve    = ($urandom_range(0, 2) == 0);
      i_br_taken      = 1'($urandom);
      cyc();
    end
    rst_n = 1;
    idle();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
